// File: rtl/logic_gate_pkg.sv
// Shared definitions for the logic gate unit: op codes, sweep FSM states
// and the truth word a correct gate core produces.
package logic_gate_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;
  localparam logic [2:0] OP_BUF  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Truth word for ops 7..0, one nibble per op, bit index {a,b}.
  localparam logic [31:0] TT_EXPECT = 32'hC3961E78;

endpackage

// File: rtl/gate_core.sv
// Combinational bitwise gate: applies one of eight 2-input functions
// independently to every bit of the operands.
module gate_core
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // Function select; ops NOT and BUF look only at operand a.
  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_NAND: y = ~(a & b);
      OP_OR:   y = a | b;
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_NOT:  y = ~a;
      OP_BUF:  y = a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_gate_unit.sv
// Registered multi-function gate unit with valid/ready handshake and a
// built-in truth-table sweep that exercises the shared gate core.
module logic_gate_unit
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [31:0]      tt
);

  state_t           state, state_nxt;
  logic [4:0]       idx;
  logic             accept;
  logic             start_go;
  logic             sweeping;
  logic [2:0]       core_op;
  logic [WIDTH-1:0] core_a;
  logic [WIDTH-1:0] core_b;
  logic [WIDTH-1:0] core_y;
  logic             vld_p1;
  logic [WIDTH-1:0] y_p1;

  assign sweeping  = (state == ST_SWEEP);
  assign in_ready  = (state == ST_IDLE) && (!vld_p1 || out_ready);
  assign accept    = in_valid && in_ready;
  // A sweep may only start from an empty output stage, and never in the
  // same cycle a beat is taken, so the two users of the core never collide.
  assign start_go  = (state == ST_IDLE) && start && !vld_p1 && !accept;

  // The sweep generator owns the core while sweeping.
  assign core_op = sweeping ? idx[4:2] : op;
  assign core_a  = sweeping ? {WIDTH{idx[1]}} : a;
  assign core_b  = sweeping ? {WIDTH{idx[0]}} : b;

  gate_core #(.WIDTH(WIDTH)) u_core (
    .op (core_op),
    .a  (core_a),
    .b  (core_b),
    .y  (core_y)
  );

  // Sweep FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Sweep FSM next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_go) state_nxt = ST_SWEEP;
      end
      ST_SWEEP: begin
        busy = 1'b1;
        if (idx == 5'd31) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Sweep index and truth-word capture; tt holds between sweeps.
  always_ff @(posedge clk) begin
    if (rst) begin
      tt  <= '0;
      idx <= '0;
    end else if (start_go) begin
      tt  <= '0;
      idx <= '0;
    end else if (sweeping) begin
      tt[idx] <= core_y[0];
      idx     <= idx + 5'd1;
    end
  end

  // ---- stage p1: registered result ----
  // Output register: load on accept, otherwise drain on consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      y_p1   <= '0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
      y_p1   <= core_y;
    end else if (vld_p1 && out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign y         = y_p1;

endmodule

// File: doc/logic_gate_unit.md
Name: logic_gate_unit

Overview:
- Parametrised, registered multi-function bitwise gate unit; successor to the single-bit, single-function NAND cell.
- Applies one of eight 2-input gate functions bitwise across WIDTH-bit operands, with a valid/ready handshake and one registered output stage.
- Includes a built-in truth-table sweep: an FSM drives all op/input combinations through the gate core and captures a 32-bit truth word for self-check.
- Used as the standard gate primitive in larger datapaths and for gate-library bring-up.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  unit can accept operand beat
op  input  3  function select (encoding below)
a  input  WIDTH  operand A
b  input  WIDTH  operand B (ignored for ops 6,7)
out_valid  output  1  result register holds valid data
out_ready  input  1  downstream accepts result
y  output  WIDTH  registered result
start  input  1  request truth-table sweep
busy  output  1  sweep in progress
done  output  1  one-cycle pulse, sweep complete
tt  output  32  captured truth word

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high. All state changes on the rising edge of `clk`.
- Op encoding: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 BUF a. Purely bitwise; there is no carry and no cross-bit logic.
- Reset values: out_valid=0, y=0, busy=0, done=0, tt=0, FSM=IDLE.
- Handshake:
  - in_ready = (FSM==IDLE) && (!out_valid || out_ready).
  - Accept occurs when in_valid && in_ready. On the next edge, y = f(op,a,b) and out_valid=1. Latency is 1 cycle.
  - Result consumed when out_valid && out_ready. If no new accept happens in the same cycle, out_valid clears on the next edge.
  - Simultaneous consume and accept: y reloads, out_valid stays 1. Full throughput of 1 beat/cycle.
  - With out_valid=1 && out_ready=0, y and out_valid hold stable and in_ready=0.
- Sweep FSM:
  - States: IDLE, SWEEP, DONE.
  - IDLE->SWEEP: when start=1 && out_valid=0 && no accept this cycle. On entry: tt cleared to 0, 5-bit index idx cleared to 0.
  - start while out_valid=1 is ignored, not queued. start is ignored in SWEEP and DONE.
  - SWEEP: each cycle the core is driven with op=idx[4:2], a={WIDTH{idx[1]}}, b={WIDTH{idx[0]}}. tt[idx] <= result bit 0; idx increments. After idx=31 is captured -> DONE. Sweep takes exactly 32 cycles. busy=1 throughout SWEEP.
  - DONE: done=1 for one cycle, busy=0, then -> IDLE. tt holds until the next sweep or reset.
  - in_ready=0 in SWEEP and DONE. External in_valid is ignored there, and y/out_valid are untouched.
- Expected tt for a correct core: 0xC3961E78. Per-op nibbles, op7..op0: C,3,9,6,1,E,7,8.
- Reset mid-sweep: returns to IDLE, tt=0, no done pulse.
- Reset with out_valid=1: result dropped.
- WIDTH=1 is legal; all behaviour is unchanged.

Decomposition:
- Shared package `logic_gate_pkg`:
  - op encoding localparams OP_AND..OP_BUF (3-bit)
  - FSM state encoding
  - TT_EXPECT=32'hC3961E78
- Sub-module `gate_core`: combinational, parameter WIDTH; inputs op,a,b; output y. Instantiated once, with its inputs muxed between the external operands and the sweep generator.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, y=0, busy=0, done=0, tt=0 on release.
- WIDTH=8, op=1, a=0xF0, b=0xCC, out_ready=1 -> next cycle out_valid=1, y=0x3F. Repeat for all ops, e.g. op=4 -> y=0x3C, op=6 -> y=0x0F.
- Back-pressure: out_ready=0 and two beats offered -> first result held, in_ready=0, second beat accepted only in the cycle out_ready rises; streaming at out_ready=1 gives 1 result/cycle in order.
- Sweep: start=1 in IDLE with out_valid=0 -> busy high 32 cycles, done pulses on cycle 33, tt=0xC3961E78; in_valid during sweep is not accepted.
- start while out_valid=1 && out_ready=0 -> busy stays 0, sweep not started.
- rst asserted at sweep cycle 10 -> busy=0, tt=0, no done pulse; a fresh sweep then yields 0xC3961E78.
